// File: rtl/conv_pkg.sv
// Shared constants, word type and scheduler state encoding for the conv sequencer.
package conv_pkg;

    localparam int SIZE       = 7;
    localparam int N          = 32;
    localparam int K          = SIZE * SIZE;
    localparam int IDX_W      = $clog2(K);
    localparam int CNT_W      = 4;
    localparam int SETTLE_DEF = 2;

    typedef logic [N-1:0] word_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_FILT = 3'd1,
        S_LOAD_WIN  = 3'd2,
        S_SETTLE    = 3'd3,
        S_OUT       = 3'd4
    } sched_state_e;

endpackage

// File: rtl/conv_sched_if.sv
// Filter, window and result valid/ready streams of the conv sequencer.
interface conv_sched_if;
    import conv_pkg::*;

    logic  filt_valid;
    logic  filt_ready;
    word_t filt_data;
    logic  win_valid;
    logic  win_ready;
    word_t win_data;
    logic  out_valid;
    logic  out_ready;
    word_t out_data;

    modport master (
        output filt_valid, filt_data, win_valid, win_data, out_ready,
        input  filt_ready, win_ready, out_valid, out_data
    );

    modport slave (
        input  filt_valid, filt_data, win_valid, win_data, out_ready,
        output filt_ready, win_ready, out_valid, out_data
    );

endinterface

// File: rtl/conv_load_reg.sv
// K-entry indexed register file exposed as one flat bus; word i sits at bits [i*N +: N].
module conv_load_reg
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  word_t            wdata,
    output logic [K*N-1:0]   rdata_bus
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K - 1);

    logic [K*N-1:0] bus_q;
    logic [K*N-1:0] bus_d;

    // Write one slot; out-of-range indices are dropped so nothing aliases.
    always_comb begin
        bus_d = bus_q;
        if (we && (idx <= IDX_LAST)) begin
            bus_d[int'(idx)*N +: N] = wdata;
        end else begin
            bus_d = bus_q;
        end
    end

    // Slot storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_q <= '0;
        end else begin
            bus_q <= bus_d;
        end
    end

    assign rdata_bus = bus_q;

endmodule

// File: rtl/conv_sched.sv
// Serial loader and result capture for one combinational 7x7 conv instance.
module conv_sched
    import conv_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    conv_sched_if.slave    bus,
    output logic [K*N-1:0] filter_bus,
    output logic [K*N-1:0] window_bus,
    input  word_t          conv_result,
    output logic           filt_loaded,
    output logic           busy,
    output logic [15:0]    frames_done
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE);

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    word_t            out_data_q, out_data_d;
    logic             filt_loaded_q, filt_loaded_d;
    logic [15:0]      frames_done_q, frames_done_d;

    logic filt_ready_s, win_ready_s, busy_s;
    logic filt_hs_s, win_hs_s, out_hs_s, idx_last_s, settle_done_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a pending filter always wins over a pending window.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.filt_valid) begin
                    state_d = S_LOAD_FILT;
                end else if (bus.win_valid && filt_loaded_q) begin
                    state_d = S_LOAD_WIN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_FILT: begin
                if (filt_hs_s && idx_last_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LOAD_FILT;
                end
            end
            S_LOAD_WIN: begin
                if (win_hs_s && idx_last_s) begin
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_LOAD_WIN;
                end
            end
            S_SETTLE: begin
                if (settle_done_s) begin
                    state_d = S_OUT;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_OUT: begin
                if (out_hs_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded readies and handshake qualifiers.
    always_comb begin
        filt_ready_s  = (state_q == S_LOAD_FILT);
        win_ready_s   = (state_q == S_LOAD_WIN);
        busy_s        = (state_q != S_IDLE);
        filt_hs_s     = filt_ready_s && bus.filt_valid;
        win_hs_s      = win_ready_s && bus.win_valid;
        out_hs_s      = out_valid_q && bus.out_ready;
        idx_last_s    = (idx_q == IDX_LAST);
        settle_done_s = (cnt_q <= 4'd1);
    end

    // Index, settle counter, result capture and frame counting.
    always_comb begin
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        filt_loaded_d = filt_loaded_q;
        frames_done_d = frames_done_q;
        case (state_q)
            S_IDLE: begin
                if (bus.filt_valid) begin
                    filt_loaded_d = 1'b0;
                end else begin
                    filt_loaded_d = filt_loaded_q;
                end
            end
            S_LOAD_FILT: begin
                if (filt_hs_s && idx_last_s) begin
                    idx_d         = '0;
                    filt_loaded_d = 1'b1;
                end else if (filt_hs_s) begin
                    idx_d = idx_q + 1'b1;
                end else begin
                    idx_d = idx_q;
                end
            end
            S_LOAD_WIN: begin
                if (win_hs_s && idx_last_s) begin
                    idx_d = '0;
                    cnt_d = CNT_INIT;
                end else if (win_hs_s) begin
                    idx_d = idx_q + 1'b1;
                end else begin
                    idx_d = idx_q;
                end
            end
            S_SETTLE: begin
                if (settle_done_s) begin
                    cnt_d       = 4'd0;
                    out_valid_d = 1'b1;
                    out_data_d  = conv_result;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_OUT: begin
                if (out_hs_s) begin
                    out_valid_d   = 1'b0;
                    frames_done_d = frames_done_q + 16'd1;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            default: begin
                idx_d       = '0;
                cnt_d       = 4'd0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q         <= '0;
            cnt_q         <= 4'd0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            filt_loaded_q <= 1'b0;
            frames_done_q <= 16'd0;
        end else begin
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            filt_loaded_q <= filt_loaded_d;
            frames_done_q <= frames_done_d;
        end
    end

    conv_load_reg u_filt_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (filt_hs_s),
        .idx       (idx_q),
        .wdata     (bus.filt_data),
        .rdata_bus (filter_bus)
    );

    conv_load_reg u_win_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (win_hs_s),
        .idx       (idx_q),
        .wdata     (bus.win_data),
        .rdata_bus (window_bus)
    );

    assign bus.filt_ready = filt_ready_s;
    assign bus.win_ready  = win_ready_s;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign filt_loaded    = filt_loaded_q;
    assign busy           = busy_s;
    assign frames_done    = frames_done_q;

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched with a behavioural Q16.15 multiply-accumulate conv model.
module tb_conv_sched;
    import conv_pkg::*;

    logic           clk;
    logic           rst_n;
    logic [K*N-1:0] filter_bus;
    logic [K*N-1:0] window_bus;
    word_t          conv_result;
    logic           filt_loaded;
    logic           busy;
    logic [15:0]    frames_done;

    int checks   = 0;
    int failures = 0;
    int exp_frames;

    conv_sched_if sif ();

    conv_sched #(.SETTLE(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (sif),
        .filter_bus  (filter_bus),
        .window_bus  (window_bus),
        .conv_result (conv_result),
        .filt_loaded (filt_loaded),
        .busy        (busy),
        .frames_done (frames_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural conv: sum of per-tap Q16.15 products.
    logic signed [63:0] m_f, m_w, m_acc;
    always_comb begin
        m_f   = '0;
        m_w   = '0;
        m_acc = '0;
        for (int i = 0; i < K; i++) begin
            m_f   = 64'($signed(filter_bus[i*N +: N]));
            m_w   = 64'($signed(window_bus[i*N +: N]));
            m_acc = m_acc + ((m_f * m_w) >>> 15);
        end
        conv_result = m_acc[31:0];
    end

    function automatic word_t word_of(input int mode, input int i);
        word_t one;
        one = 32'h0000_8000;
        if (mode == 1) return one;
        return (i % 2 == 1) ? one : 32'h0000_0000;
    endfunction

    function automatic logic [K*N-1:0] bus_of(input int mode);
        logic [K*N-1:0] b;
        b = '0;
        for (int i = 0; i < K; i++) b[i*N +: N] = word_of(mode, i);
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic [K*N-1:0] obs, input logic [K*N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Stream `stop_at` words of a pattern; returns at the negedge after the last accepted beat.
    task automatic send(input bit is_filt, input int mode, input bit gaps, input int stop_at);
        int  i = 0;
        int  guard = 0;
        bit  v;
        bit  rdy;
        while (i < stop_at && guard < 1000) begin
            @(negedge clk);
            v = !(gaps && ($urandom_range(0, 1) == 0));
            if (is_filt) begin
                sif.filt_valid = v;
                sif.filt_data  = word_of(mode, i);
                rdy = sif.filt_ready;
            end else begin
                sif.win_valid = v;
                sif.win_data  = word_of(mode, i);
                rdy = sif.win_ready;
            end
            @(posedge clk);
            if (v && rdy) i++;
            guard++;
        end
        @(negedge clk);
        sif.filt_valid = 1'b0;
        sif.win_valid  = 1'b0;
        check(is_filt ? "filt_beats" : "win_beats", 32'(i), 32'(stop_at));
    endtask

    task automatic wait_out();
        for (int c = 0; c < 20 && !sif.out_valid; c++) @(negedge clk);
        check("out_valid_rise", 32'(sif.out_valid), 32'd1);
    endtask

    // At a negedge with out_valid high: check result, hand it off, check the counter.
    task automatic finish_out(input string tag);
        check({tag, "_data"}, sif.out_data, 32'h000C_0000);
        sif.out_ready = 1'b1;
        @(negedge clk);
        sif.out_ready = 1'b0;
        exp_frames = (exp_frames + 1) % 65536;
        check({tag, "_valid_drop"}, 32'(sif.out_valid), 32'd0);
        check({tag, "_frames"}, 32'(frames_done), 32'(exp_frames));
    endtask

    initial begin
        rst_n          = 1'b0;
        sif.filt_valid = 1'b0;
        sif.filt_data  = '0;
        sif.win_valid  = 1'b0;
        sif.win_data   = '0;
        sif.out_ready  = 1'b0;
        exp_frames     = 0;
        repeat (3) @(negedge clk);

        check("rst_out_valid", 32'(sif.out_valid), 32'd0);
        check("rst_out_data", sif.out_data, 32'd0);
        check("rst_filt_loaded", 32'(filt_loaded), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frames", 32'(frames_done), 32'd0);
        check_bus("rst_filter_bus", filter_bus, '0);
        check_bus("rst_window_bus", window_bus, '0);
        rst_n = 1'b1;

        // A window offered with no filter must be refused.
        sif.win_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("nofilt_win_ready", 32'(sif.win_ready), 32'd0);
            check("nofilt_busy", 32'(busy), 32'd0);
        end
        sif.win_valid = 1'b0;

        // Scenario 1: alternating-tap filter and window, exact latency.
        send(1'b1, 0, 1'b0, K);
        check("s1_filt_loaded", 32'(filt_loaded), 32'd1);
        check("s1_idle_after_filt", 32'(busy), 32'd0);
        check_bus("s1_filter_bus", filter_bus, bus_of(0));
        send(1'b0, 0, 1'b0, K);
        check("s1_valid_lat0", 32'(sif.out_valid), 32'd0);
        @(negedge clk);
        check("s1_valid_lat1", 32'(sif.out_valid), 32'd0);
        @(negedge clk);
        check("s1_valid_lat2", 32'(sif.out_valid), 32'd1);
        finish_out("s1");

        // Scenario 2: all-ones window, result held under back-pressure.
        send(1'b0, 1, 1'b0, K);
        wait_out();
        sif.win_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("s2_hold_valid", 32'(sif.out_valid), 32'd1);
            check("s2_hold_data", sif.out_data, 32'h000C_0000);
            check("s2_hold_win_ready", 32'(sif.win_ready), 32'd0);
            check("s2_hold_frames", 32'(frames_done), 32'(exp_frames));
        end
        sif.win_valid = 1'b0;
        finish_out("s2");

        // Scenario 4: random valid gaps, conv inputs frozen while settling.
        send(1'b1, 0, 1'b1, K);
        check("s4_filt_loaded", 32'(filt_loaded), 32'd1);
        send(1'b0, 0, 1'b1, K);
        check_bus("s4_settle_filter", filter_bus, bus_of(0));
        check_bus("s4_settle_window", window_bus, bus_of(0));
        @(negedge clk);
        check_bus("s4_settle_filter2", filter_bus, bus_of(0));
        check_bus("s4_settle_window2", window_bus, bus_of(0));
        wait_out();
        finish_out("s4");

        // Scenario 5: asynchronous reset in the middle of a window.
        send(1'b0, 1, 1'b0, 30);
        check("s5_busy_mid", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_out_valid", 32'(sif.out_valid), 32'd0);
        check("s5_rst_filt_loaded", 32'(filt_loaded), 32'd0);
        check("s5_rst_busy", 32'(busy), 32'd0);
        check("s5_rst_frames", 32'(frames_done), 32'd0);
        check_bus("s5_rst_window_bus", window_bus, '0);
        exp_frames = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b1, 0, 1'b0, K);
        send(1'b0, 0, 1'b0, K);
        wait_out();
        finish_out("s5");

        // Scenario 6: counter preset to 0xFFFF, next hand-off wraps to zero.
        force dut.frames_done_q = 16'hFFFF;
        @(negedge clk);
        release dut.frames_done_q;
        @(negedge clk);
        check("s6_preset", 32'(frames_done), 32'h0000_FFFF);
        exp_frames = 65535;
        send(1'b0, 0, 1'b0, K);
        wait_out();
        finish_out("s6_wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_sched.md
Name: conv_sched

Overview:
Sequencer for the 7x7 combinational convolution datapath (conv, Q16.15 signed words).
- Serially loads the filter and input-window registers that drive conv's flat buses.
- Waits a fixed settle time, captures conv_output, and presents it on a valid/ready result port.
- Sits between the feature-map fetch logic and the conv array, so a narrow one-word-per-cycle stream can reuse one conv instance.

Parameters:
SIZE, 7, kernel edge; K = SIZE*SIZE words per filter/window
N, 32, word width (1 sign, 16 integer, 15 fraction bits)
SETTLE, 2, cycles allowed for the combinational conv to settle before capture; legal range 1..15

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
filt_valid  in  1  filter word offered
filt_ready  out  1  filter word accepted when valid&ready
filt_data  in  N  filter coefficient, sent in index order 0..K-1
win_valid  in  1  window word offered
win_ready  out  1  window word accepted when valid&ready
win_data  in  N  window pixel, sent in index order 0..K-1
filter_bus  out  K*N  to conv.filter; word i occupies bits [i*N +: N]
window_bus  out  K*N  to conv.conv_input; same packing
conv_result  in  N  from conv.conv_output
out_valid  out  1  result available
out_ready  in  1  result consumed when valid&ready
out_data  out  N  captured conv result
filt_loaded  out  1  a complete filter is held
busy  out  1  state != IDLE
frames_done  out  16  count of results handed off; wraps at 0xFFFF->0

Behaviour:
- Reset (async, rst_n=0) clears the following:
  - state=IDLE, idx=0, settle counter=0;
  - filter_bus=0, window_bus=0, out_data=0;
  - out_valid=0, filt_loaded=0, frames_done=0.
- States: IDLE, LOAD_FILT, LOAD_WIN, SETTLE, OUT. A single idx counter (0..K-1, 6 bits for default) is shared by both load states.
- IDLE transitions:
  - filt_valid has priority: go to LOAD_FILT and clear filt_loaded in the same edge.
  - Otherwise, if win_valid && filt_loaded, go to LOAD_WIN.
  - A window offered with no filter loaded waits with win_ready=0.
- Readies are combinational on state only:
  - filt_ready=1 only in LOAD_FILT.
  - win_ready=1 only in LOAD_WIN.
  - Entry to a load state costs one cycle; the first word is taken the cycle after entry.
- LOAD_FILT: each handshake writes filt_data to filter slot idx, then idx++. On the handshake with idx=K-1: idx=0, filt_loaded=1, go to IDLE.
- LOAD_WIN: the same with window slots. On the handshake with idx=K-1: idx=0, settle counter=SETTLE, go to SETTLE.
- Gaps: a deasserted valid inside a load state stalls without a timeout. win_valid is ignored during LOAD_FILT and vice versa.
- SETTLE: the counter decrements each cycle. When the counter is 1, on that edge:
  - out_data<=conv_result, out_valid<=1, go to OUT.
  - Net latency: out_valid rises SETTLE cycles after the edge accepting the last window word.
- OUT: out_valid held, out_data stable until out_ready. On the handshake: out_valid<=0, frames_done++, go to IDLE.
  - No new load is accepted while in OUT (no overlap).
- Bus stability: filter_bus is stable outside LOAD_FILT. window_bus is stable outside LOAD_WIN, so conv inputs never change during SETTLE.
- Filter reload starts only from IDLE and invalidates filt_loaded until the reload completes, so a partial filter is never used.
- Reset mid-operation: immediate return to reset values. The partial filter or window is discarded; the upstream must restart at index 0.
- No arithmetic on data; words pass through bit-exact.

Decomposition:
- Shared package conv_pkg holds:
  - constants SIZE and N;
  - derived K and IDX_W = $clog2(K);
  - typedef word_t (logic [N-1:0]);
  - the state enum sched_state_e.
- A sub-module is natural: conv_load_reg (K-entry shift-free indexed register file with a write port and a flat bus output), instantiated twice for filter and window.
- conv itself stays outside; the bench connects both.

Test Plan:
- Reset, then a filter of K words (odd idx=32'h00008000, even=0), then a window with the same pattern. Required: filt_loaded=1 after the 49th filter beat; out_valid 2 cycles after the 49th window beat; out_data=32'h000C0000 (24.0).
- After filt_loaded, a window with all words 32'h00008000. Required: out_data=32'h000C0000 again (only 24 nonzero taps). Hold out_ready=0 for 10 cycles: out_valid and out_data stay stable, win_ready=0 throughout, frames_done increments once on release.
- win_valid asserted from reset with no filter loaded. Required: win_ready stays 0 for 20 cycles; busy=0.
- Random valid gaps (50% duty) on both streams with the same data as scenario 1. Required: identical result 32'h000C0000; filter_bus and window_bus unchanged during SETTLE.
- rst_n pulsed low asynchronously at window beat 30. Required: out_valid=0 and filt_loaded=0 immediately, state IDLE; a full filter+window reload afterwards produces the correct result.
- 65537 back-to-back frames (shortened via force, or frames_done preset) -> frames_done wraps 0xFFFF->0x0000.
